fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL provide parameter RESET_PC, default 32'd0: PC value loaded by reset and by start.
REQ-002 SHALL provide parameter PC_LIMIT, default 4096: instruction-memory depth; the last fetchable address is PC_LIMIT-1.
REQ-003 SHALL provide parameter HALT_OPCODE, default 9'b111111111: instruction encoding that ends the program.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port start, input, 1 bit: begin fetching from RESET_PC; honoured only in IDLE or HALTED.
REQ-007 SHALL have port stall, input, 1 bit: hold PC and output register this cycle.
REQ-008 SHALL have port branch_taken, input, 1 bit: redirect PC to branch_target.
REQ-009 SHALL have port branch_target, input, 32 bits: absolute redirect address.
REQ-010 SHALL have port instruction, input, 9 bits: combinational instruction-memory read data for current_pc.
REQ-011 SHALL have port current_pc, output, 32 bits: address driven to instruction memory.
REQ-012 SHALL have port fetched_instr, output, 9 bits: registered instruction.
REQ-013 SHALL have port fetched_pc, output, 32 bits: address fetched_instr came from.
REQ-014 SHALL have port instr_valid, output, 1 bit: fetched_instr/fetched_pc hold a new instruction this cycle.
REQ-015 SHALL have port done, output, 1 bit: high while in HALTED.
REQ-016 SHALL have port instr_count, output, 32 bits: number of instructions delivered since last start or reset.

Function
REQ-017 SHALL implement states IDLE, FETCH and HALTED.
REQ-018 SHALL move IDLE->FETCH or HALTED->FETCH on start=1, loading pc=RESET_PC, clearing instr_count and instr_valid.
REQ-019 SHALL drive current_pc directly from the pc register in all states, giving zero added latency to memory.
REQ-020 SHALL, in FETCH with stall=0 and branch_taken=0, set the following on the next edge: fetched_instr=instruction, fetched_pc=pc, instr_valid=1, pc=pc+1 modulo 2^32, instr_count+1.
REQ-021 SHALL, in FETCH with stall=1 and branch_taken=0, hold pc, fetched_instr, fetched_pc and instr_count, and drive instr_valid=0 on the next cycle.
REQ-022 SHALL, in FETCH with branch_taken=1, set the following on the next edge regardless of stall: pc=branch_target, instr_valid=0 (flush), instr_count unchanged.
REQ-023 SHALL apply priority reset > branch_taken > stall > normal advance.
REQ-024 SHALL, when a delivered instruction equals HALT_OPCODE, deliver it (instr_valid=1) and enter HALTED on the same edge, with pc unchanged.
REQ-025 SHALL, when delivering the instruction at pc=PC_LIMIT-1, deliver it and enter HALTED on the same edge, with pc unchanged.
REQ-026 SHALL, if pc>=PC_LIMIT at a FETCH cycle (e.g. an out-of-range branch), enter HALTED without delivering, with instr_valid=0.
REQ-027 SHALL drive instr_valid=0 in IDLE and HALTED, and ignore stall and branch_taken in those states.
REQ-028 SHALL make instr_valid a one-cycle pulse per delivered instruction; it is never held across a stall.
REQ-029 SHALL let instr_count wrap 32'hFFFFFFFF->0 without error.

Reset
REQ-030 SHALL, on reset=1 at a rising edge, set state=IDLE, pc=RESET_PC, fetched_instr=0, fetched_pc=0, instr_valid=0, done=0 and instr_count=0.
REQ-031 SHALL let reset mid-FETCH or in HALTED abandon all activity, with no instruction delivered on that edge.
REQ-032 SHALL ignore start while reset=1.

Verification
REQ-033 SHALL cover linear fetch: memory 0..3 = 9'h001,9'h002,9'h003,HALT_OPCODE; pulse start. Required: instr_valid for four consecutive cycles, fetched_pc 0,1,2,3; done=1 after the fourth; instr_count=4; current_pc holds 3.
REQ-034 SHALL cover stall: stall=1 for 2 cycles after the first delivery. Required: instr_valid=0 for those cycles, current_pc held at 1; resume delivers fetched_pc=1 with no skip or duplicate.
REQ-035 SHALL cover branch: branch_taken=1, branch_target=32'd100 while pc=2, with stall=1 the same cycle. Required: next cycle instr_valid=0 and current_pc=100; following cycle fetched_pc=100.
REQ-036 SHALL cover limits: branch to PC_LIMIT-1 gives one delivery then done=1; branch to PC_LIMIT gives done=1 with no delivery.
REQ-037 SHALL cover reset mid-run: reset at pc=5. Required: next cycle state IDLE, current_pc=RESET_PC, all outputs zero; start then restarts cleanly with instr_count from 0.
REQ-038 SHALL cover restart from HALTED: start pulse reloads RESET_PC and clears instr_count and done, and fetching resumes.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch unit: drives a PC to a combinational instruction memory
// and registers each delivered instruction with its address.
module fetch_unit #(
  parameter logic [31:0] RESET_PC    = 32'd0,
  parameter int unsigned PC_LIMIT    = 4096,
  parameter logic [8:0]  HALT_OPCODE = 9'b111111111
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic [8:0]  instruction,
  output logic [31:0] current_pc,
  output logic [8:0]  fetched_instr,
  output logic [31:0] fetched_pc,
  output logic        instr_valid,
  output logic        done,
  output logic [31:0] instr_count
);

  typedef enum logic [1:0] {IDLE, FETCH, HALTED} state_t;

  localparam logic [31:0] LIMIT = 32'(PC_LIMIT);
  localparam logic [31:0] LAST  = LIMIT - 32'd1;

  state_t      state, state_nx;
  logic [31:0] pc, pc_nx;
  logic [8:0]  instr_q, instr_nx;
  logic [31:0] fpc_q, fpc_nx;
  logic        valid_q, valid_nx;
  logic [31:0] count_q, count_nx;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      pc      <= RESET_PC;
      instr_q <= '0;
      fpc_q   <= '0;
      valid_q <= 1'b0;
      count_q <= '0;
    end else begin
      state   <= state_nx;
      pc      <= pc_nx;
      instr_q <= instr_nx;
      fpc_q   <= fpc_nx;
      valid_q <= valid_nx;
      count_q <= count_nx;
    end
  end

  always_comb begin
    state_nx = state;
    pc_nx    = pc;
    instr_nx = instr_q;
    fpc_nx   = fpc_q;
    valid_nx = 1'b0;
    count_nx = count_q;
    unique case (state)
      IDLE, HALTED: begin
        if (start) begin
          state_nx = FETCH;
          pc_nx    = RESET_PC;
          count_nx = '0;
        end
      end
      FETCH: begin
        // Redirect beats the range check so a branch out of range halts next cycle.
        if (branch_taken) begin
          pc_nx = branch_target;
        end else if (pc >= LIMIT) begin
          state_nx = HALTED;
        end else if (!stall) begin
          instr_nx = instruction;
          fpc_nx   = pc;
          valid_nx = 1'b1;
          count_nx = count_q + 32'd1;
          if (instruction == HALT_OPCODE || pc == LAST)
            state_nx = HALTED;
          else
            pc_nx = pc + 32'd1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign current_pc    = pc;
  assign fetched_instr = instr_q;
  assign fetched_pc    = fpc_q;
  assign instr_valid   = valid_q;
  assign instr_count   = count_q;
  assign done          = (state == HALTED);

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: vector table plus hand-written reset sequence.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset, start, stall, branch_taken;
  logic [31:0] branch_target;
  logic [8:0]  instruction;
  logic [31:0] current_pc, fetched_pc, instr_count;
  logic [8:0]  fetched_instr;
  logic        instr_valid, done;

  logic [8:0]  mem [4096];
  int unsigned errors = 0;
  int unsigned checks = 0;

  fetch_unit #(.RESET_PC(32'd0), .PC_LIMIT(4096), .HALT_OPCODE(9'h1FF)) dut (
    .clk(clk), .reset(reset), .start(start), .stall(stall),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .instruction(instruction), .current_pc(current_pc),
    .fetched_instr(fetched_instr), .fetched_pc(fetched_pc),
    .instr_valid(instr_valid), .done(done), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  assign instruction = (current_pc < 32'd4096) ? mem[current_pc[11:0]] : '0;

  typedef struct {
    logic        st, sl, br;
    logic [31:0] tgt;
    logic        ev, chkf;
    logic [31:0] efpc;
    logic [8:0]  eins;
    logic [31:0] ecur;
    logic        edone;
    logic [31:0] ecnt;
  } vec_t;

  vec_t vecs [22];

  function automatic vec_t mk(input logic st, input logic sl, input logic br,
                              input logic [31:0] tgt, input logic ev, input logic chkf,
                              input logic [31:0] efpc, input logic [8:0] eins,
                              input logic [31:0] ecur, input logic edone,
                              input logic [31:0] ecnt);
    vec_t v;
    v.st = st; v.sl = sl; v.br = br; v.tgt = tgt; v.ev = ev; v.chkf = chkf;
    v.efpc = efpc; v.eins = eins; v.ecur = ecur; v.edone = edone; v.ecnt = ecnt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input logic st, input logic sl, input logic br, input logic [31:0] tgt);
    start = st; stall = sl; branch_taken = br; branch_target = tgt;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_outs(input string tag, input logic ev, input logic [31:0] ecur,
                          input logic edone, input logic [31:0] ecnt);
    chk({tag, ".instr_valid"}, 32'(instr_valid), 32'(ev));
    chk({tag, ".current_pc"}, current_pc, ecur);
    chk({tag, ".done"}, 32'(done), 32'(edone));
    chk({tag, ".instr_count"}, instr_count, ecnt);
  endtask

  initial begin
    int unsigned budget;
    for (int i = 0; i < 4096; i++) mem[i] = '0;
    mem[0] = 9'h001; mem[1] = 9'h002; mem[2] = 9'h003; mem[3] = 9'h1FF;
    mem[100] = 9'h0AA; mem[101] = 9'h1FF; mem[4095] = 9'h055;

    //           st sl br tgt    ev chkf efpc   eins    ecur   done cnt
    vecs[0]  = mk(1, 0, 0, 0,    0, 0, 0,    9'h000, 0,    0, 0);  // start from IDLE
    vecs[1]  = mk(0, 0, 0, 0,    1, 1, 0,    9'h001, 1,    0, 1);
    vecs[2]  = mk(0, 0, 0, 0,    1, 1, 1,    9'h002, 2,    0, 2);
    vecs[3]  = mk(0, 0, 0, 0,    1, 1, 2,    9'h003, 3,    0, 3);
    vecs[4]  = mk(0, 0, 0, 0,    1, 1, 3,    9'h1FF, 3,    1, 4);  // halt opcode
    vecs[5]  = mk(0, 0, 0, 0,    0, 1, 3,    9'h1FF, 3,    1, 4);
    vecs[6]  = mk(0, 1, 1, 50,   0, 1, 3,    9'h1FF, 3,    1, 4);  // ignored in HALTED
    vecs[7]  = mk(1, 0, 0, 0,    0, 0, 0,    9'h000, 0,    0, 0);  // restart
    vecs[8]  = mk(0, 0, 0, 0,    1, 1, 0,    9'h001, 1,    0, 1);
    vecs[9]  = mk(0, 1, 0, 0,    0, 1, 0,    9'h001, 1,    0, 1);  // stall
    vecs[10] = mk(0, 1, 0, 0,    0, 1, 0,    9'h001, 1,    0, 1);
    vecs[11] = mk(0, 0, 0, 0,    1, 1, 1,    9'h002, 2,    0, 2);
    vecs[12] = mk(0, 1, 1, 100,  0, 1, 1,    9'h002, 100,  0, 2);  // branch beats stall
    vecs[13] = mk(0, 0, 0, 0,    1, 1, 100,  9'h0AA, 101,  0, 3);
    vecs[14] = mk(0, 0, 0, 0,    1, 1, 101,  9'h1FF, 101,  1, 4);
    vecs[15] = mk(1, 0, 0, 0,    0, 0, 0,    9'h000, 0,    0, 0);
    vecs[16] = mk(0, 0, 1, 4095, 0, 0, 0,    9'h000, 4095, 0, 0);
    vecs[17] = mk(0, 0, 0, 0,    1, 1, 4095, 9'h055, 4095, 1, 1);  // last address
    vecs[18] = mk(1, 0, 0, 0,    0, 0, 0,    9'h000, 0,    0, 0);
    vecs[19] = mk(0, 0, 1, 4096, 0, 0, 0,    9'h000, 4096, 0, 0);
    vecs[20] = mk(0, 0, 0, 0,    0, 0, 0,    9'h000, 4096, 1, 0);  // out of range
    vecs[21] = mk(0, 0, 0, 0,    0, 0, 0,    9'h000, 4096, 1, 0);

    reset = 1'b1; start = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_outs("reset", 1'b0, 32'd0, 1'b0, 32'd0);
    chk("reset.fetched_pc", fetched_pc, 32'd0);
    chk("reset.fetched_instr", 32'(fetched_instr), 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 22; i++) begin
      step(vecs[i].st, vecs[i].sl, vecs[i].br, vecs[i].tgt);
      chk_outs($sformatf("vec%0d", i), vecs[i].ev, vecs[i].ecur, vecs[i].edone, vecs[i].ecnt);
      if (vecs[i].chkf) begin
        chk($sformatf("vec%0d.fetched_pc", i), fetched_pc, vecs[i].efpc);
        chk($sformatf("vec%0d.fetched_instr", i), 32'(fetched_instr), 32'(vecs[i].eins));
      end
    end

    // Reset mid-run at pc=5, with start held high to show it is ignored under reset.
    mem[3] = 9'h004;
    step(1, 0, 0, 0);
    budget = 0;
    while (current_pc != 32'd5 && budget < 20) begin
      step(0, 0, 0, 0);
      budget++;
    end
    chk("midrun.reach_pc5", current_pc, 32'd5);
    chk("midrun.count_before", instr_count, 32'd5);
    reset = 1'b1;
    step(1, 0, 0, 0);
    reset = 1'b0;
    chk_outs("midrun.reset", 1'b0, 32'd0, 1'b0, 32'd0);
    chk("midrun.fetched_pc", fetched_pc, 32'd0);
    chk("midrun.fetched_instr", 32'(fetched_instr), 32'd0);
    step(0, 0, 0, 0);
    chk_outs("midrun.idle", 1'b0, 32'd0, 1'b0, 32'd0);
    step(1, 0, 0, 0);
    chk_outs("midrun.start", 1'b0, 32'd0, 1'b0, 32'd0);
    step(0, 0, 0, 0);
    chk_outs("midrun.first", 1'b1, 32'd1, 1'b0, 32'd1);
    chk("midrun.first_fpc", fetched_pc, 32'd0);
    chk("midrun.first_instr", 32'(fetched_instr), 32'h001);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
